// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two producers, the write arbiter and the FIFO write pins.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 32
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_full;
  logic              almost_full;
  logic [1:0]        grant;
  logic              err_ovf;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, wr_full, almost_full,
    output req0_ready, req1_ready, wr_data, wr_en, grant, err_ovf, cnt0, cnt1
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, wr_full, almost_full,
    input  req0_ready, req1_ready, wr_data, wr_en, grant, err_ovf, cnt0, cnt1
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between two producers.
// Optional per-requester word counters are built when FIFO_WR_ARB_CNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 12,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            tb_rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t            state_reg;
  logic              last_reg;
  logic [BC_W-1:0]   burst_cnt_reg;
  logic              wr_en_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              err_ovf_reg;
  logic [1:0]        grant_reg;

  logic space_ok;
  logic rdy0;
  logic rdy1;
  logic acc0;
  logic acc1;
  logic cur_valid;
  logic burst_last;

  // Ready drops in the same cycle as almost_full, so at most the word already
  // registered reaches the FIFO after the flag rises.
  assign space_ok   = ~bus.almost_full & ~bus.wr_full;
  assign rdy0       = (state_reg == G0) & space_ok;
  assign rdy1       = (state_reg == G1) & space_ok;
  assign acc0       = rdy0 & bus.req0_valid;
  assign acc1       = rdy1 & bus.req1_valid;
  assign cur_valid  = (state_reg == G0) ? bus.req0_valid : bus.req1_valid;
  assign burst_last = (burst_cnt_reg == BC_W'(MAX_BURST - 1));

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.grant      = grant_reg;
  assign bus.err_ovf    = err_ovf_reg;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
      wr_en_reg     <= 1'b0;
      wr_data_reg   <= '0;
      err_ovf_reg   <= 1'b0;
      grant_reg     <= 2'b00;
    end else begin
      wr_en_reg <= acc0 | acc1;
      if (acc0) begin
        wr_data_reg <= bus.req0_data;
      end else if (acc1) begin
        wr_data_reg <= bus.req1_data;
      end
      if (wr_en_reg & bus.wr_full) begin
        err_ovf_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          // On a tie the requester that did not own the last grant wins.
          if (bus.req0_valid & (~bus.req1_valid | last_reg)) begin
            state_reg <= G0;
            grant_reg <= 2'b01;
          end else if (bus.req1_valid) begin
            state_reg <= G1;
            grant_reg <= 2'b10;
          end
        end
        G0, G1: begin
          // A stall holds the grant regardless of valid; exits only happen with space.
          if (space_ok) begin
            if (cur_valid & ~burst_last) begin
              burst_cnt_reg <= burst_cnt_reg + BC_W'(1);
            end else begin
              state_reg     <= IDLE;
              grant_reg     <= 2'b00;
              last_reg      <= (state_reg == G1);
              burst_cnt_reg <= '0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_reg;
  logic [CNT_W-1:0] cnt1_reg;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
    end else begin
      if (acc0) cnt0_reg <= cnt0_reg + CNT_W'(1);
      if (acc1) cnt1_reg <= cnt1_reg + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt0_reg;
  assign bus.cnt1 = cnt1_reg;
`else
  assign bus.cnt0 = '0;
  assign bus.cnt1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues, a write scoreboard, a 1024-word
// FIFO model and a log of completed bursts.
module tb_fifo_wr_arbiter;
  localparam int DW    = 12;
  localparam int DEPTH = 1024;
  localparam int AF_TH = 1020;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_W(DW), .CNT_W(32)) bus ();

  fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(16), .CNT_W(32)) dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .bus    (bus.master)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] p0_q[$];
  logic [DW-1:0] p1_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] fifo_q[$];
  int            log_g[$];
  int            log_len[$];

  logic hold0 = 1'b0, hold1 = 1'b0;
  logic force_af = 1'b0, force_full = 1'b0;
  logic drain_en = 1'b0;
  int   cur_len, idle_cnt, n_wr, n_acc, rd_idx, cyc;
  logic [31:0] m_cnt0, m_cnt1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb_q.delete(); fifo_q.delete(); log_g.delete(); log_len.delete();
    cur_len = 0; idle_cnt = 0; n_wr = 0; n_acc = 0; rd_idx = 0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Entered and left at a falling edge.
  task automatic cycle();
    logic [1:0] g;
    logic a0, a1;
    bus.req0_valid  = (p0_q.size() > 0) && !hold0;
    bus.req0_data   = (p0_q.size() > 0) ? p0_q[0] : '0;
    bus.req1_valid  = (p1_q.size() > 0) && !hold1;
    bus.req1_data   = (p1_q.size() > 0) ? p1_q[0] : '0;
    bus.almost_full = force_af || (fifo_q.size() >= AF_TH);
    bus.wr_full     = force_full || (fifo_q.size() >= DEPTH);
    #2;
    g  = bus.grant;
    a0 = bus.req0_valid & bus.req0_ready;
    a1 = bus.req1_valid & bus.req1_ready;
    if (!g[0]) check("nongrant_rdy0", {31'd0, bus.req0_ready}, 32'd0);
    if (!g[1]) check("nongrant_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    if (bus.almost_full) check("af_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    if (bus.wr_en) begin
      if (!force_full) check("wr_en_while_full", {31'd0, bus.wr_full}, 32'd0);
      if (!bus.wr_full) fifo_q.push_back(bus.wr_data);
    end
    if (a0) begin sb_q.push_back(p0_q[0]); m_cnt0++; end
    if (a1) begin sb_q.push_back(p1_q[0]); m_cnt1++; end
    if (a0 || a1) begin cur_len++; n_acc++; end
    if (g == 2'b00 && (p0_q.size() > 0 || p1_q.size() > 0)) idle_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (a0) void'(p0_q.pop_front());
    if (a1) void'(p1_q.pop_front());
    if (bus.wr_en) begin
      n_wr++;
      if (sb_q.size() == 0) check("spurious_wr_en", 32'd1, 32'd0);
      else check("wr_data", {20'd0, bus.wr_data}, {20'd0, sb_q.pop_front()});
    end
    if (drain_en && fifo_q.size() >= 1016 && (cyc % 4 == 0)) begin
      check("readback", {20'd0, fifo_q.pop_front()}, rd_idx & 32'hfff);
      rd_idx++;
    end
    if (g != 2'b00 && bus.grant == 2'b00) begin
      log_g.push_back(int'(g)); log_len.push_back(cur_len); cur_len = 0;
    end
    $display("[TB] t=%0t grant=%b acc=%b%b wr_en=%b wr_data=%h af=%b full=%b err=%b",
             $time, g, a1, a0, bus.wr_en, bus.wr_data, bus.almost_full, bus.wr_full, bus.err_ovf);
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
`ifdef FIFO_WR_ARB_CNT_EN
    check({tag, "_cnt0"}, bus.cnt0, m_cnt0);
    check({tag, "_cnt1"}, bus.cnt1, m_cnt1);
`else
    check({tag, "_cnt0"}, bus.cnt0, 32'd0);
    check({tag, "_cnt1"}, bus.cnt1, 32'd0);
`endif
  endtask

  task automatic do_reset();
    tb_rst = 1'b1;
    #1;
    check("rst_grant", {30'd0, bus.grant}, 32'd0);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
    clear_model();
    check("rst_wr_data", {20'd0, bus.wr_data}, 32'd0);
    check("rst_err_ovf", {31'd0, bus.err_ovf}, 32'd0);
    check_cnt("rst");
  endtask

  task automatic run_until_drained(input int budget, input string tag);
    int i;
    for (i = 0; i < budget && (p0_q.size() > 0 || p1_q.size() > 0 || sb_q.size() > 0); i++) cycle();
    check({tag, "_budget"}, {31'd0, (i < budget)}, 32'd1);
    repeat (2) cycle();
  endtask

  task automatic check_burst(input string tag, input int idx, input int g, input int len);
    check({tag, "_grant"}, (idx < log_g.size()) ? log_g[idx] : -1, g);
    check({tag, "_len"}, (idx < log_len.size()) ? log_len[idx] : -1, len);
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_data = '0; bus.req1_valid = 0; bus.req1_data = '0;
    bus.almost_full = 0; bus.wr_full = 0;
    cyc = 0;
    clear_model();
    @(negedge clk);
    do_reset();

    // 1: single producer, 40 words -> 16/16/8 with one idle cycle before each burst
    for (int i = 0; i < 40; i++) p0_q.push_back(DW'(12'h100 + i));
    run_until_drained(200, "t1");
    check("t1_nwr", n_wr, 40);
    check("t1_nbursts", log_g.size(), 3);
    check_burst("t1_b0", 0, 1, 16);
    check_burst("t1_b1", 1, 1, 16);
    check_burst("t1_b2", 2, 1, 8);
    check("t1_idle_cycles", idle_cnt, 3);
    check_cnt("t1");

    // 2: both streaming -> alternating grants, req0 first
    do_reset();
    for (int i = 0; i < 40; i++) begin
      p0_q.push_back(DW'(12'h400 + i));
      p1_q.push_back(DW'(12'h800 + i));
    end
    run_until_drained(300, "t2");
    check("t2_nwr", n_wr, 80);
    check("t2_nbursts", log_g.size(), 6);
    check_burst("t2_b0", 0, 1, 16);
    check_burst("t2_b1", 1, 2, 16);
    check_burst("t2_b2", 2, 1, 16);
    check_burst("t2_b3", 3, 2, 16);
    check_burst("t2_b4", 4, 1, 8);
    check_burst("t2_b5", 5, 2, 8);
    check_cnt("t2");

    // 3: almost_full mid-burst stalls the grant, even with valid dropped
    do_reset();
    for (int i = 0; i < 20; i++) p0_q.push_back(DW'(12'h300 + i));
    for (int i = 0; i < 20 && n_acc < 5; i++) cycle();
    begin
      int wr_before;
      wr_before = n_wr;
      force_af = 1'b1;
      repeat (2) cycle();
      hold0 = 1'b1;
      repeat (2) cycle();
      check("t3_af_inflight_le1", {31'd0, (n_wr - wr_before) <= 1}, 32'd1);
      check("t3_af_acc_frozen", n_acc, 5);
      check("t3_af_grant_held", {30'd0, bus.grant}, 32'd1);
      force_af = 1'b0;
      hold0 = 1'b0;
      cycle();
      check("t3_resume_acc", n_acc, 6);
      check("t3_resume_grant", {30'd0, bus.grant}, 32'd1);
    end
    run_until_drained(100, "t3");
    check("t3_nwr", n_wr, 20);
    check_burst("t3_b0", 0, 1, 16);
    check_burst("t3_b1", 1, 1, 4);

    // 4: 1024 words from req1 into the FIFO model with a slow reader near the top
    do_reset();
    drain_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) p1_q.push_back(DW'(i));
    run_until_drained(3000, "t4");
    drain_en = 1'b0;
    while (fifo_q.size() > 0) begin
      check("t4_readback", {20'd0, fifo_q.pop_front()}, rd_idx & 32'hfff);
      rd_idx++;
    end
    check("t4_read_count", rd_idx, DEPTH);
    check("t4_err_ovf", {31'd0, bus.err_ovf}, 32'd0);
    check_cnt("t4");

    // 5: wr_full forced under a pending wr_en -> sticky err_ovf
    do_reset();
    p1_q.push_back(DW'(12'h5a5));
    for (int i = 0; i < 10 && n_wr < 1; i++) cycle();
    check("t5_pending_wr_en", {31'd0, bus.wr_en}, 32'd1);
    force_full = 1'b1;
    cycle();
    check("t5_err_set", {31'd0, bus.err_ovf}, 32'd1);
    force_full = 1'b0;
    repeat (5) cycle();
    check("t5_err_sticky", {31'd0, bus.err_ovf}, 32'd1);

    // 6: reset at the 5th word of a burst; req0 must win the first tie afterwards
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p0_q.push_back(DW'(12'h600 + i));
      p1_q.push_back(DW'(12'h700 + i));
    end
    for (int i = 0; i < 20 && n_acc < 5; i++) cycle();
    check("t6_inflight_wr_en", {31'd0, bus.wr_en}, 32'd1);
    check("t6_grant_before", {30'd0, bus.grant}, 32'd1);
    check_cnt("t6_pre");
    do_reset();
    cycle();
    check("t6_first_tie", {30'd0, bus.grant}, 32'd1);
    run_until_drained(200, "t6");
    check("t6_nwr", n_wr, 35);
    check_burst("t6_b0", 0, 1, 15);
    check_burst("t6_b1", 1, 2, 16);
    check_cnt("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end
endmodule
